wb_cmd_master: RTL and testbench
================================

Name: wb_cmd_master

Overview:
- Synthesizable Wishbone initiator. Turns simple command requests into Wishbone classic and incrementing-burst cycles toward the SDRAM controller's Wishbone slave port.
- It is the requesting end of the controller's Wishbone port: it drives what the controller samples (wb_*_i) and consumes what the controller returns (wb_ack_o, wb_dat_o).
- It holds off all traffic until the controller reports SDRAM initialisation complete.
- It guards every beat with an ack timeout.

Parameters:
- dw, 32, Wishbone data width in bits.
- APP_AW, 26, Wishbone address width in bits.
- MAX_BURST, 8, maximum beats per command (power of two).
- TIMEOUT, 255, cycles a strobed beat may wait for ack before abort.

Ports:
- sys_clk  in  1  sole clock; all logic on the rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- sdr_init_done  in  1  SDRAM controller initialisation complete.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when valid&ready at an edge.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  APP_AW  byte address of the first beat.
- cmd_len  in  $clog2(MAX_BURST)  beats minus 1.
- cmd_sel  in  dw/8  byte enables, applied to every beat.
- wr_data  in  dw  write beat data.
- wr_valid  in  1  write data available.
- wr_ready  out  1  write data consumed when valid&ready at an edge.
- rd_data  out  dw  captured read data.
- rd_valid  out  1  one-cycle pulse per read beat.
- done  out  1  one-cycle pulse, command completed normally.
- err  out  1  one-cycle pulse, command aborted by timeout.
- wb_cyc_i, wb_stb_i, wb_we_i  out  1 each  Wishbone cycle, strobe, write enable.
- wb_addr_i  out  APP_AW  Wishbone address.
- wb_dat_i  out  dw  Wishbone write data.
- wb_sel_i  out  dw/8  Wishbone byte select.
- wb_cti_i  out  3  Wishbone cycle type identifier.
- wb_ack_o  in  1  Wishbone acknowledge from the slave.
- wb_dat_o  in  dw  Wishbone read data from the slave.

Behaviour:
- Reset: while wb_rst_i=1, all outputs are 0 and state = INIT, immediately and asynchronously. Reset mid-burst drops cyc/stb at once with no done/err pulse.
- INIT: cmd_ready=0. Move to IDLE on the first edge sampling sdr_init_done=1.
- IDLE:
  - cmd_ready=1.
  - If sdr_init_done=0, return to INIT; cmd_ready is gated low combinationally that cycle.
  - On accept, latch we/addr/len/sel and set beat counter = cmd_len; next cycle state = XFER with cyc=1.
- XFER, read: stb=1 from the first XFER cycle, held through all beats, address presented.
- XFER, write:
  - wr_ready = we & (!stb | ack).
  - A wr handshake loads wb_dat_i and sets stb=1 next cycle.
  - If ack occurs without a new handshake, stb drops to 0 next cycle (wait state). stb never rises without valid data.
- Beat completes at an edge with stb&ack.
  - addr += dw/8, wrapping modulo 2^APP_AW.
  - Counter decrements.
  - Read: rd_data <= wb_dat_o, rd_valid=1 the following cycle.
- cti encoding:
  - cmd_len=0 → 3'b000 on the single beat.
  - Bursts → 3'b010 on all beats except the last, 3'b111 on the last (counter=0).
  - cti is valid whenever stb=1.
- Last-beat ack: next cycle cyc=stb=0, done=1, state = IDLE. Back-to-back commands therefore have at least 1 idle cycle with cyc=0.
- Timeout:
  - Counter clears on every ack and whenever stb=0; it increments each cycle stb=1 & !ack.
  - On reaching TIMEOUT: next cycle cyc=stb=0, err=1, state = IDLE. Remaining beats and any pending write data are discarded.
- ack sampled while stb=0 is ignored.
- sdr_init_done falling during XFER is ignored until the command ends.
- done and err are never asserted together.
- wb_we_i/wb_sel_i are constant for the whole cycle.
- wb_rst_i is this block's input only; it does not drive the controller's reset.

Test Plan:
- Reset asserted, sdr_init_done=0 for 20 cycles -> cmd_ready=0, cyc=0; set init_done=1 -> cmd_ready=1 the cycle after the sampling edge.
- Single write: addr=0x40, sel=4'hF, data=0xDEADBEEF, slave acks on the 3rd strobed cycle -> cyc/stb high 3 cycles, cti=000, we=1, then done pulse, cyc=0.
- 4-beat read: addr=0x100, len=3, zero-wait slave returning 0xA0..0xA3 -> addresses 0x100/104/108/10C, cti 010,010,010,111, rd_valid 4 consecutive cycles with data A0..A3, done once.
- 4-beat write, wr_valid low 2 cycles before beat 3 -> stb low exactly those cycles, address holds 0x108, all 4 data delivered in order, done once.
- Address wrap: read at 2^26-4, len=1 -> second beat addr=0x0000000, cti 010 then 111.
- Slave never acks, TIMEOUT=255 -> stb high exactly 255 cycles, then cyc=0, err=1 for one cycle, done=0; next command is accepted normally.

Source files
------------

// File: rtl/wb_cmd_master_if.sv
// Wishbone bus bundle between the command master and the SDRAM controller's
// slave port. Signal names follow the controller's view (_i = into slave).
interface wb_cmd_master_if #(
  parameter int dw     = 32,
  parameter int APP_AW = 26
);
  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic              wb_we_i;
  logic [APP_AW-1:0] wb_addr_i;
  logic [dw-1:0]     wb_dat_i;
  logic [dw/8-1:0]   wb_sel_i;
  logic [2:0]        wb_cti_i;
  logic              wb_ack_o;
  logic [dw-1:0]     wb_dat_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i, wb_cti_i,
    input  wb_ack_o, wb_dat_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i, wb_cti_i,
    output wb_ack_o, wb_dat_o
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone initiator: turns single commands into classic or incrementing-burst
// Wishbone cycles, waits for SDRAM init, and aborts any beat that is not
// acknowledged within TIMEOUT strobed cycles.
module wb_cmd_master #(
  parameter int dw        = 32,
  parameter int APP_AW    = 26,
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                         sys_clk,
  input  logic                         wb_rst_i,
  input  logic                         sdr_init_done,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_we,
  input  logic [APP_AW-1:0]            cmd_addr,
  input  logic [$clog2(MAX_BURST)-1:0] cmd_len,
  input  logic [dw/8-1:0]              cmd_sel,
  input  logic [dw-1:0]                wr_data,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  output logic [dw-1:0]                rd_data,
  output logic                         rd_valid,
  output logic                         done,
  output logic                         err,
  wb_cmd_master_if.master              wb
);

  localparam int LW = $clog2(MAX_BURST);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [APP_AW-1:0] BEAT_BYTES = APP_AW'(dw / 8);
  localparam logic [TW-1:0]     TO_LAST    = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t            state;
  logic              ready_r;
  logic              cyc_r;
  logic              stb_r;
  logic              we_r;
  logic              single_r;
  logic [APP_AW-1:0] addr_r;
  logic [dw-1:0]     wdat_r;
  logic [dw/8-1:0]   sel_r;
  logic [2:0]        cti_r;
  logic [LW-1:0]     cnt_r;
  logic [TW-1:0]     to_r;
  logic [dw-1:0]     rd_data_r;
  logic              rd_valid_r;
  logic              done_r;
  logic              err_r;

  logic              beat_done;
  logic              last_beat;
  logic              to_hit;

  // Cycle type for the beat about to be presented, given beats left after it.
  function automatic logic [2:0] cti_for(input logic single, input logic [LW-1:0] beats_left);
    if (single)
      return 3'b000;
    else if (beats_left == '0)
      return 3'b111;
    else
      return 3'b010;
  endfunction

  // An ack only counts while strobing; a lone ack with stb low is ignored.
  assign beat_done = stb_r & wb.wb_ack_o;
  assign last_beat = beat_done & (cnt_r == '0);
  // The wait counter is about to reach TIMEOUT on this edge.
  assign to_hit    = stb_r & ~wb.wb_ack_o & (to_r == TO_LAST);

  // Write data is taken when nothing is strobed, or when the current beat is
  // completing and more beats remain; never beyond the last beat.
  assign wr_ready  = (state == XFER) & we_r & (~stb_r | (beat_done & (cnt_r != '0)));
  // Init loss in IDLE blocks acceptance in the same cycle.
  assign cmd_ready = ready_r & sdr_init_done;

  assign rd_data   = rd_data_r;
  assign rd_valid  = rd_valid_r;
  assign done      = done_r;
  assign err       = err_r;

  assign wb.wb_cyc_i  = cyc_r;
  assign wb.wb_stb_i  = stb_r;
  assign wb.wb_we_i   = we_r;
  assign wb.wb_addr_i = addr_r;
  assign wb.wb_dat_i  = wdat_r;
  assign wb.wb_sel_i  = sel_r;
  assign wb.wb_cti_i  = cti_r;

  // Command FSM with all bus and status outputs registered.
  always_ff @(posedge sys_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= INIT;
      ready_r    <= 1'b0;
      cyc_r      <= 1'b0;
      stb_r      <= 1'b0;
      we_r       <= 1'b0;
      single_r   <= 1'b0;
      addr_r     <= '0;
      wdat_r     <= '0;
      sel_r      <= '0;
      cti_r      <= 3'b000;
      cnt_r      <= '0;
      to_r       <= '0;
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      rd_valid_r <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;

      case (state)
        INIT: begin
          if (sdr_init_done) begin
            state   <= IDLE;
            ready_r <= 1'b1;
          end
        end

        IDLE: begin
          if (!sdr_init_done) begin
            state   <= INIT;
            ready_r <= 1'b0;
          end else if (cmd_valid) begin
            state    <= XFER;
            ready_r  <= 1'b0;
            cyc_r    <= 1'b1;
            // Reads strobe immediately; writes wait for the first data beat.
            stb_r    <= ~cmd_we;
            we_r     <= cmd_we;
            addr_r   <= cmd_addr;
            sel_r    <= cmd_sel;
            cnt_r    <= cmd_len;
            single_r <= (cmd_len == '0);
            cti_r    <= cti_for(cmd_len == '0, cmd_len);
            to_r     <= '0;
          end
        end

        XFER: begin
          if (!stb_r || wb.wb_ack_o)
            to_r <= '0;
          else
            to_r <= to_r + TW'(1);

          if (to_hit) begin
            // Abort: drop the cycle, discard remaining beats.
            state   <= IDLE;
            ready_r <= 1'b1;
            cyc_r   <= 1'b0;
            stb_r   <= 1'b0;
            cti_r   <= 3'b000;
            err_r   <= 1'b1;
          end else begin
            if (beat_done) begin
              addr_r <= addr_r + BEAT_BYTES;
              cnt_r  <= cnt_r - LW'(1);
              cti_r  <= cti_for(single_r, cnt_r - LW'(1));
              if (!we_r) begin
                rd_data_r  <= wb.wb_dat_o;
                rd_valid_r <= 1'b1;
              end
            end

            if (last_beat) begin
              state   <= IDLE;
              ready_r <= 1'b1;
              cyc_r   <= 1'b0;
              stb_r   <= 1'b0;
              cti_r   <= 3'b000;
              done_r  <= 1'b1;
            end else if (we_r) begin
              if (wr_valid && wr_ready) begin
                wdat_r <= wr_data;
                stb_r  <= 1'b1;
              end else if (beat_done) begin
                stb_r  <= 1'b0;
              end
            end
          end
        end

        default: begin
          state   <= INIT;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: directed scenarios plus randomized commands,
// with a Wishbone slave model and a transaction-level reference model.
module tb_wb_cmd_master;
  localparam int DW = 32;
  localparam int AW = 26;
  localparam int MB = 8;
  localparam int TO = 255;

  logic          sys_clk = 1'b0;
  logic          wb_rst_i;
  logic          sdr_init_done;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [2:0]    cmd_len;
  logic [3:0]    cmd_sel;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          done;
  logic          err;

  wb_cmd_master_if #(.dw(DW), .APP_AW(AW)) bus ();

  wb_cmd_master #(.dw(DW), .APP_AW(AW), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .sys_clk       (sys_clk),
    .wb_rst_i      (wb_rst_i),
    .sdr_init_done (sdr_init_done),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_we        (cmd_we),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .cmd_sel       (cmd_sel),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .done          (done),
    .err           (err),
    .wb            (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [2:0]    cti;
    logic          we;
    logic [3:0]    sel;
    logic [DW-1:0] wdat;
  } beat_t;

  int tests = 0;
  int fails = 0;

  beat_t         beat_q[$];
  logic [DW-1:0] rdv_q[$];
  logic [DW-1:0] wd_q[$];
  int            gap_q[$];
  int            done_n, err_n, both_n, stb_hi_n, stb_lo_n;
  int            gap_cnt = 0;
  bit            hs = 1'b0;
  int            wc = 0;
  int            slave_wait = 0;
  bit            never_ack = 1'b0;
  bit            spurious = 1'b0;
  int            gap_plan[8];
  logic [DW-1:0] dat_plan[8];

  // Slave memory image: data is a function of the beat address.
  function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
    logic [AW-1:0] d;
    d = a - 26'h100;
    return 32'h000000A0 + {8'h00, d[AW-1:2]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave, write-data producer and monitor: drive on negedge, sample 2 later.
  always @(negedge sys_clk) begin
    beat_t b;
    if (hs) begin
      hs = 1'b0;
      wr_valid = 1'b0;
      if (wd_q.size() > 0) void'(wd_q.pop_front());
      gap_cnt = (gap_q.size() > 0) ? gap_q.pop_front() : 0;
    end
    if (!wr_valid && wd_q.size() > 0) begin
      if (gap_cnt > 0) gap_cnt--;
      else begin
        wr_valid = 1'b1;
        wr_data  = wd_q[0];
      end
    end
    if (bus.wb_cyc_i && bus.wb_stb_i) begin
      if (bus.wb_ack_o) wc = 0;
      if (!never_ack && wc >= slave_wait) begin
        bus.wb_ack_o = 1'b1;
        bus.wb_dat_o = slave_data(bus.wb_addr_i);
      end else begin
        bus.wb_ack_o = 1'b0;
        wc++;
      end
    end else begin
      wc = 0;
      bus.wb_ack_o = spurious && bus.wb_cyc_i && ($urandom_range(1) == 1);
      bus.wb_dat_o = $urandom;
    end
    #2;
    if (bus.wb_cyc_i && bus.wb_stb_i && bus.wb_ack_o) begin
      b.addr = bus.wb_addr_i;
      b.cti  = bus.wb_cti_i;
      b.we   = bus.wb_we_i;
      b.sel  = bus.wb_sel_i;
      b.wdat = bus.wb_dat_i;
      beat_q.push_back(b);
    end
    if (wr_valid && wr_ready) hs = 1'b1;
    if (rd_valid) rdv_q.push_back(rd_data);
    if (done) done_n++;
    if (err) err_n++;
    if (done && err) both_n++;
    if (bus.wb_cyc_i && bus.wb_stb_i) stb_hi_n++;
    if (bus.wb_cyc_i && !bus.wb_stb_i) stb_lo_n++;
  end

  // Issue one command, wait for it to end, compare against the model.
  task automatic do_cmd(input string tag, input bit we, input logic [AW-1:0] addr,
                        input int len, input logic [3:0] sel);
    bit ok;
    int nb, exp_hi, exp_lo, n;
    logic [AW-1:0] ea;
    @(posedge sys_clk); #1;
    beat_q.delete(); rdv_q.delete();
    done_n = 0; err_n = 0; both_n = 0; stb_hi_n = 0; stb_lo_n = 0;
    if (we) begin
      wd_q.delete(); gap_q.delete();
      for (int k = 0; k <= len; k++) wd_q.push_back(dat_plan[k]);
      for (int k = 1; k <= len; k++) gap_q.push_back(gap_plan[k]);
      gap_cnt = 0;
    end
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = 3'(len); cmd_sel = sel;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk); #3;
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    chk({tag, " accept"}, 64'(ok), 64'd1);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge sys_clk); #1;
      if (done_n + err_n > 0) begin ok = 1'b1; break; end
    end
    repeat (3) @(posedge sys_clk);
    #1;
    chk({tag, " complete"}, 64'(ok), 64'd1);

    nb     = never_ack ? 0 : len + 1;
    exp_hi = never_ack ? TO : (len + 1) * (slave_wait + 1);
    exp_lo = 0;
    if (we) begin
      exp_lo = 1;
      for (int k = 1; k <= len; k++)
        if (gap_plan[k] > slave_wait) exp_lo += gap_plan[k] - slave_wait;
    end
    chk({tag, " done"}, 64'(done_n), never_ack ? 64'd0 : 64'd1);
    chk({tag, " err"}, 64'(err_n), never_ack ? 64'd1 : 64'd0);
    chk({tag, " done&err"}, 64'(both_n), 64'd0);
    chk({tag, " beats"}, 64'(beat_q.size()), 64'(nb));
    n = (beat_q.size() < nb) ? beat_q.size() : nb;
    for (int k = 0; k < n; k++) begin
      ea = addr + AW'(4 * k);
      chk($sformatf("%s addr%0d", tag, k), 64'(beat_q[k].addr), 64'(ea));
      chk($sformatf("%s cti%0d", tag, k), 64'(beat_q[k].cti),
          (len == 0) ? 64'd0 : ((k == len) ? 64'd7 : 64'd2));
      chk($sformatf("%s we%0d", tag, k), 64'(beat_q[k].we), 64'(we));
      chk($sformatf("%s sel%0d", tag, k), 64'(beat_q[k].sel), 64'(sel));
      if (we) chk($sformatf("%s wdat%0d", tag, k), 64'(beat_q[k].wdat), 64'(dat_plan[k]));
    end
    chk({tag, " rd count"}, 64'(rdv_q.size()), we ? 64'd0 : 64'(nb));
    n = (rdv_q.size() < nb) ? rdv_q.size() : nb;
    for (int k = 0; k < n; k++) begin
      if (!we) chk($sformatf("%s rdat%0d", tag, k), 64'(rdv_q[k]), 64'(slave_data(addr + AW'(4 * k))));
    end
    chk({tag, " stb high cycles"}, 64'(stb_hi_n), 64'(exp_hi));
    chk({tag, " stb low cycles"}, 64'(stb_lo_n), 64'(exp_lo));
    chk({tag, " cyc idle after"}, 64'(bus.wb_cyc_i), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached with %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    wb_rst_i = 1'b1; sdr_init_done = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0;
    cmd_addr = '0; cmd_len = '0; cmd_sel = '0;
    for (int k = 0; k < 8; k++) begin gap_plan[k] = 0; dat_plan[k] = '0; end

    // Reset with init pending
    repeat (20) @(posedge sys_clk);
    @(negedge sys_clk); #1;
    chk("rst cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst cyc", 64'(bus.wb_cyc_i), 64'd0);
    chk("rst stb", 64'(bus.wb_stb_i), 64'd0);
    chk("rst wr_ready", 64'(wr_ready), 64'd0);
    chk("rst pulses", 64'({done, err, rd_valid}), 64'd0);
    chk("rst addr/cti", 64'({bus.wb_addr_i, bus.wb_cti_i}), 64'd0);
    @(posedge sys_clk); #1;
    wb_rst_i = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("init wait cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge sys_clk);
    sdr_init_done = 1'b1;
    #1;
    chk("init before edge", 64'(cmd_ready), 64'd0);
    @(posedge sys_clk); #1;
    chk("init after edge", 64'(cmd_ready), 64'd1);

    // Single write, slave acks on 3rd strobed cycle
    slave_wait = 2; dat_plan[0] = 32'hDEADBEEF;
    do_cmd("wr1", 1'b1, 26'h40, 0, 4'hF);

    // 4-beat zero-wait read returning A0..A3
    slave_wait = 0;
    do_cmd("rd4", 1'b0, 26'h100, 3, 4'hF);

    // 4-beat write, data stalls 2 cycles before beat 3
    for (int k = 0; k < 4; k++) dat_plan[k] = 32'h11110000 + 32'(k);
    gap_plan[0] = 0; gap_plan[1] = 0; gap_plan[2] = 2; gap_plan[3] = 0;
    do_cmd("wr4gap", 1'b1, 26'h100, 3, 4'hF);

    // Address wrap at top of space
    do_cmd("wrap", 1'b0, 26'h3FFFFFC, 1, 4'hF);

    // Slave never acks
    never_ack = 1'b1;
    do_cmd("tmo", 1'b0, 26'h80, 3, 4'h3);
    never_ack = 1'b0;
    do_cmd("after tmo", 1'b0, 26'h84, 0, 4'hC);

    // Init drop while idle gates cmd_ready at once
    @(posedge sys_clk); #1;
    sdr_init_done = 1'b0;
    #1;
    chk("init drop cmd_ready", 64'(cmd_ready), 64'd0);
    @(posedge sys_clk); #1;
    sdr_init_done = 1'b1;
    #1;
    chk("reinit before edge", 64'(cmd_ready), 64'd0);
    @(posedge sys_clk); #1;
    chk("reinit after edge", 64'(cmd_ready), 64'd1);

    // Reset in the middle of a burst
    done_n = 0; err_n = 0;
    slave_wait = 3;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 26'h200; cmd_len = 3'd7; cmd_sel = 4'hF;
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    repeat (6) @(posedge sys_clk);
    #1;
    chk("mid cyc before rst", 64'(bus.wb_cyc_i), 64'd1);
    wb_rst_i = 1'b1;
    #1;
    chk("mid rst cyc", 64'(bus.wb_cyc_i), 64'd0);
    chk("mid rst stb", 64'(bus.wb_stb_i), 64'd0);
    chk("mid rst cmd_ready", 64'(cmd_ready), 64'd0);
    chk("mid rst pulses", 64'({done, err}), 64'd0);
    repeat (2) @(posedge sys_clk);
    #1;
    wb_rst_i = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("mid rst no done/err", 64'(done_n + err_n), 64'd0);
    chk("mid rst reready", 64'(cmd_ready), 64'd1);

    // Randomized commands
    for (int r = 0; r < 25; r++) begin
      bit            rwe;
      int            rlen;
      logic [AW-1:0] raddr;
      logic [3:0]    rsel;
      rwe   = ($urandom_range(1) == 1);
      rlen  = $urandom_range(MB - 1);
      raddr = AW'($urandom) & ~26'h3;
      if (r % 5 == 0) raddr = 26'h3FFFFF0;
      rsel  = 4'($urandom);
      slave_wait = $urandom_range(3);
      spurious   = ($urandom_range(1) == 1);
      for (int k = 0; k < 8; k++) begin
        gap_plan[k] = (k == 0) ? 0 : $urandom_range(4);
        dat_plan[k] = $urandom;
      end
      do_cmd($sformatf("rnd%0d", r), rwe, raddr, rlen, rsel);
    end
    spurious = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
